// File: rtl/vga_plot_arbiter_pkg.sv
// Shared constants and FSM encoding for the VGA plot-port arbiter.
package vga_plot_arbiter_pkg;

    localparam int NREQ     = 3;
    localparam int REQ_MAP  = 0;
    localparam int REQ_CHAR = 1;
    localparam int REQ_OVL  = 2;
    localparam int MAX_HOLD = 11050;
    localparam int MIN_HOLD = 50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: first set request at or above rr_ptr, wrapping to 0.
module rr_picker #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  winner,
    output logic             valid
);

    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Arbitrates several pixel sources onto the single VGA adapter plot port.
// state | meaning
// IDLE  | no owner; grant the round-robin winner when enabled
// OWN   | one requester owns the port; hold timer running
// GAP   | one dead cycle between owners so pixels never interleave
module vga_plot_arbiter #(
    parameter int NREQ     = vga_plot_arbiter_pkg::NREQ,
    parameter int MAX_HOLD = vga_plot_arbiter_pkg::MAX_HOLD,
    parameter int MIN_HOLD = vga_plot_arbiter_pkg::MIN_HOLD
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   px_plot,
    input  logic [8*NREQ-1:0] px_x,
    input  logic [8*NREQ-1:0] px_y,
    input  logic [3*NREQ-1:0] px_color,
    output logic [NREQ-1:0]   grant,
    output logic              vga_plot,
    output logic [7:0]        vga_x,
    output logic [7:0]        vga_y,
    output logic [2:0]        vga_color,
    output logic [15:0]       preempt_cnt
);
    import vga_plot_arbiter_pkg::*;

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t        state, state_nx;
    logic [NREQ-1:0]   grant_nx;
    logic [PTR_W-1:0]  owner, owner_nx;
    logic [PTR_W-1:0]  rr_ptr, rr_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [NREQ-1:0]   pick;
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic              preempt_hit;
    logic              at_max, min_met, others;

    rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign at_max  = (hold_cnt >= HOLD_W'(MAX_HOLD));
    assign min_met = (32'(hold_cnt) >= MIN_HOLD);
    assign others  = |(req & ~grant);

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        owner_nx    = owner;
        rr_nx       = rr_ptr;
        hold_nx     = hold_cnt;
        preempt_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                grant_nx = '0;
                if (en && pick_valid) begin
                    state_nx = ST_OWN;
                    grant_nx = pick;
                    owner_nx = pick_idx;
                    rr_nx    = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    hold_nx  = '0;
                end
            end
            ST_OWN: begin
                // Disable and release take precedence over preemption so neither is counted.
                if (!en || !req[owner]) begin
                    state_nx = ST_GAP;
                    grant_nx = '0;
                    hold_nx  = '0;
                end else if (at_max && min_met && others) begin
                    state_nx    = ST_GAP;
                    grant_nx    = '0;
                    hold_nx     = '0;
                    preempt_hit = 1'b1;
                end else if (at_max) begin
                    hold_nx = others ? hold_cnt : '0;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            preempt_cnt <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_nx;
            hold_cnt <= hold_nx;
            if (preempt_hit && preempt_cnt != 16'hFFFF) preempt_cnt <= preempt_cnt + 16'd1;
        end
    end

    // Only the current owner's slice is ever sampled; coordinates hold while idle.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            vga_plot  <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
        end else if (|grant) begin
            vga_plot  <= px_plot[owner] & grant[owner];
            vga_x     <= px_x[int'(owner)*8 +: 8];
            vga_y     <= px_y[int'(owner)*8 +: 8];
            vga_color <= px_color[int'(owner)*3 +: 3];
        end else begin
            vga_plot <= 1'b0;
        end
    end

endmodule
